// File: rtl/mux_scan_ctrl_if.sv
// Handshake bundle between the scan controller and its driver.
// The driver supplies scan commands; the controller returns mux selects and status pulses.
interface mux_scan_ctrl_if;
  logic       start;
  logic       stop;
  logic       cont;
  logic [3:0] mask;
  logic       s1;
  logic       s2;
  logic       sel_valid;
  logic       sample;
  logic       frame_done;
  logic       busy;

  modport master (
    output start, stop, cont, mask,
    input  s1, s2, sel_valid, sample, frame_done, busy
  );

  modport slave (
    input  start, stop, cont, mask,
    output s1, s2, sel_valid, sample, frame_done, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin select-line sequencer for a 4:1 mux: walks the enabled inputs,
// holding each for DWELL cycles, and flags the consumer's sample cycle.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.slave bus
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    mask_q, mask_d;
  logic          cont_q, cont_d;

  logic       has_higher;
  logic [1:0] next_ch;
  logic [1:0] port_lowest;
  logic       last_cyc;
  logic       sample_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= 2'd0;
      cnt_q   <= '0;
      mask_q  <= 4'd0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
    end
  end

  // Descending scans so the lowest qualifying index is the one that sticks.
  always_comb begin
    has_higher  = 1'b0;
    next_ch     = 2'd0;
    port_lowest = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(ch_q) && mask_q[i]) begin
        has_higher = 1'b1;
        next_ch    = 2'(i);
      end
      if (bus.mask[i]) begin
        port_lowest = 2'(i);
      end
    end
  end

  assign last_cyc   = (state_q == ST_DWELL) && (cnt_q == LAST);
  assign sample_int = last_cyc && !bus.stop;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    cont_d  = cont_q;

    if (state_q == ST_IDLE) begin
      if (bus.start && !bus.stop && (bus.mask != 4'd0)) begin
        state_d = ST_DWELL;
        mask_d  = bus.mask;
        cont_d  = bus.cont;
        ch_d    = port_lowest;
        cnt_d   = '0;
      end
    end else begin
      if (bus.stop) begin
        state_d = ST_IDLE;
        ch_d    = 2'd0;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
        if (has_higher) begin
          ch_d = next_ch;
        end else if (cont_q && (bus.mask != 4'd0)) begin
          // Frame boundary: the port mask is only honoured here.
          mask_d = bus.mask;
          ch_d   = port_lowest;
        end else begin
          state_d = ST_IDLE;
          ch_d    = 2'd0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign bus.s1         = ch_q[1];
  assign bus.s2         = ch_q[0];
  assign bus.busy       = (state_q == ST_DWELL);
  assign bus.sel_valid  = (state_q == ST_DWELL);
  assign bus.sample     = sample_int;
  assign bus.frame_done = sample_int && !has_higher;

endmodule
